// File: rtl/uart_rx_frame_counter.sv
// uart_rx_frame_counter: UART RX bit/edge timing; in enable/clear/par_en/stop2/prescale, out edge_cnt/bit_cnt/bit_tick/sample_stb/sample_last/frame_done/busy
module uart_rx_frame_counter #(
  parameter int DATA_BITS = 8,
  parameter int PRESC_W = 6,
  localparam int BIT_W = $clog2(DATA_BITS + 4)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic               par_en,
  input  logic               stop2,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               bit_tick,
  output logic               sample_stb,
  output logic               sample_last,
  output logic               frame_done,
  output logic               busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [PRESC_W-1:0] p_sh, h;
  logic par_sh, stop_sh;
  logic [BIT_W-1:0] l_last;
  logic run, start;
  always_comb begin
    state_nx = (enable && !clear) ? RUN : IDLE;
    run = state == RUN;
    start = !run && state_nx == RUN;
    h = p_sh >> 1;
    l_last = BIT_W'(DATA_BITS + 1) + BIT_W'(par_sh) + BIT_W'(stop_sh);
    bit_tick = run && edge_cnt == p_sh - PRESC_W'(1);
    sample_stb = run && (edge_cnt == h - PRESC_W'(1) || edge_cnt == h || edge_cnt == h + PRESC_W'(1));
    sample_last = run && edge_cnt == h + PRESC_W'(1);
    frame_done = bit_tick && bit_cnt == l_last;
    busy = run;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
      p_sh <= PRESC_W'(4);
      par_sh <= 1'b0;
      stop_sh <= 1'b0;
    end else begin
      edge_cnt <= (run && state_nx == RUN && !bit_tick) ? edge_cnt + PRESC_W'(1) : '0;
      bit_cnt <= !(run && state_nx == RUN) ? '0 : frame_done ? '0 : bit_tick ? bit_cnt + BIT_W'(1) : bit_cnt;
      if (start) begin
        p_sh <= (prescale < PRESC_W'(4)) ? PRESC_W'(4) : prescale;
        par_sh <= par_en;
        stop_sh <= stop2;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// tb_uart_rx_frame_counter: scoreboard bench for uart_rx_frame_counter strobes, frame timing, clear and async reset
module tb_uart_rx_frame_counter;
  logic clk = 0, rst, enable, clear, par_en, stop2;
  logic [5:0] prescale, edge_cnt;
  logic [3:0] bit_cnt;
  logic bit_tick, sample_stb, sample_last, frame_done, busy;
  int tests = 0, fails = 0, run_cyc = 0;
  typedef struct {int cyc; int e; int b; bit stb; bit last; bit tick; bit done;} exp_t;
  exp_t q[$];
  uart_rx_frame_counter dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .par_en(par_en), .stop2(stop2),
    .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_tick(bit_tick),
    .sample_stb(sample_stb), .sample_last(sample_last), .frame_done(frame_done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input int p, input int l, input int nfr, input int lim);
    int h;
    h = p >> 1;
    for (int f = 0; f < nfr; f++)
      for (int b = 0; b < l; b++)
        for (int e = 0; e < p; e++) begin
          int c;
          bit s;
          c = (f * l + b) * p + e;
          s = e >= h - 1 && e <= h + 1;
          if (c < lim && (s || e == p - 1))
            q.push_back('{c, e, b, s, e == h + 1, e == p - 1, e == p - 1 && b == l - 1});
        end
  endtask
  always @(negedge clk) begin : mon
    exp_t x;
    if (busy) begin
      if (sample_stb || bit_tick) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_strobe: cycle %0d edge %0d bit %0d, none expected", run_cyc, edge_cnt, bit_cnt);
        end else begin
          x = q.pop_front();
          check("cycle", run_cyc, x.cyc);
          check("edge_cnt", edge_cnt, x.e);
          check("bit_cnt", bit_cnt, x.b);
          check("sample_stb", sample_stb, x.stb);
          check("sample_last", sample_last, x.last);
          check("bit_tick", bit_tick, x.tick);
          check("frame_done", frame_done, x.done);
        end
      end
      run_cyc++;
    end else begin
      if (sample_stb || bit_tick || sample_last || frame_done) begin
        tests++;
        fails++;
        $display("FAIL idle_strobe: stb %0b last %0b tick %0b done %0b, all 0 required", sample_stb, sample_last, bit_tick, frame_done);
      end
      run_cyc = 0;
    end
  end
  task automatic frame(input logic [5:0] pre, input bit par, input bit st, input int p, input int l, input int nfr, input logic [5:0] mid);
    int n;
    n = nfr * l * p;
    prescale = pre; par_en = par; stop2 = st;
    push(p, l, nfr, 1 << 30);
    enable = 1;
    repeat (n / 2) @(posedge clk);
    #1 prescale = mid; par_en = ~par; stop2 = ~st;
    repeat (n - n / 2) @(posedge clk);
    #1 enable = 0;
    @(posedge clk); #1;
    check("end_busy", busy, 0);
    check("end_bit_cnt", bit_cnt, 0);
    check("end_queue", q.size(), 0);
  endtask
  initial begin
    rst = 1; enable = 0; clear = 0; par_en = 0; stop2 = 0; prescale = 8;
    repeat (2) @(posedge clk); #1;
    check("rst_edge", edge_cnt, 0);
    check("rst_bit", bit_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {sample_stb, sample_last, bit_tick, frame_done}, 0);
    rst = 0;
    @(posedge clk); #1;
    frame(8, 0, 0, 8, 10, 1, 8);
    frame(16, 1, 1, 16, 12, 1, 8);
    frame(2, 0, 0, 4, 10, 1, 2);
    prescale = 8; par_en = 0; stop2 = 0;
    push(8, 10, 1, 38);
    push(4, 10, 1, 1 << 30);
    enable = 1;
    repeat (38) @(posedge clk);
    #1;
    check("clr_at_edge", edge_cnt, 5);
    check("clr_at_bit", bit_cnt, 4);
    clear = 1; prescale = 4;
    @(posedge clk); #1;
    check("clr_edge", edge_cnt, 0);
    check("clr_bit", bit_cnt, 0);
    check("clr_busy", busy, 0);
    clear = 0;
    @(posedge clk); #1;
    check("restart_busy", busy, 1);
    repeat (39) @(posedge clk);
    #1 enable = 0;
    @(posedge clk); #1;
    check("clr_queue", q.size(), 0);
    check("clr_end_busy", busy, 0);
    prescale = 8;
    push(8, 10, 1, 19);
    enable = 1;
    repeat (20) @(posedge clk);
    #2 rst = 1; enable = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_edge", edge_cnt, 0);
    check("arst_bit", bit_cnt, 0);
    check("arst_strobes", {sample_stb, sample_last, bit_tick, frame_done}, 0);
    check("arst_queue", q.size(), 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1 check("post_rst_busy", busy, 0);
    frame(8, 0, 0, 8, 10, 3, 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
